conv_mac_engine: RTL and testbench

- Streaming, parametrised successor to the combinational 3x3 conv2d dot-product block.
- Holds a per-channel filter bank and accepts one image-patch element per cycle over a valid/ready handshake.
- Accumulates through a 2-stage MAC pipeline and emits NUM_CH dot products per patch over a valid/ready output.
- Sits between the patch-fetch unit and the activation/writeback stage of the accelerator.

---
 rtl/conv_mac_engine.sv | 176 +++++++++++++++++
 tb/tb_conv_mac_engine.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_engine.sv
// Streaming multi-channel conv dot-product engine: a per-channel filter bank,
// a 2-stage multiply/accumulate pipeline and a valid/ready result port.
module conv_mac_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int FILTER_SIZE = 3,
  parameter int NUM_CH      = 4,
  parameter int ACC_WIDTH   = 2*DATA_WIDTH + $clog2(FILTER_SIZE*FILTER_SIZE)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          cfg_signed,
  input  logic                                          cfg_relu,
  input  logic                                          w_valid,
  output logic                                          w_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] w_ch,
  input  logic [$clog2(FILTER_SIZE*FILTER_SIZE)-1:0]    w_idx,
  input  logic [DATA_WIDTH-1:0]                         w_data,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [DATA_WIDTH-1:0]                         in_data,
  input  logic                                          in_last,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [NUM_CH*ACC_WIDTH-1:0]                   out_data,
  output logic                                          err_last,
  output logic                                          busy
);

  localparam int TAPS   = FILTER_SIZE * FILTER_SIZE;
  localparam int IDX_W  = $clog2(TAPS);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_OUTPUT
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]                    tap;
  logic                                signed_q;
  logic                                relu_q;
  logic                                mode_signed;
  logic                                in_fire;
  logic                                w_fire;
  logic                                start;
  logic                                at_last;
  logic                                s1_valid;
  logic [NUM_CH-1:0][PROD_W-1:0]       s1_prod;
  logic [NUM_CH-1:0][PROD_W-1:0]       prod_next;
  logic [NUM_CH-1:0][ACC_WIDTH-1:0]    acc;
  logic [NUM_CH-1:0][ACC_WIDTH-1:0]    out_q;
  logic                                err_q;
  logic [DATA_WIDTH-1:0]               wbank [NUM_CH][TAPS];

  assign in_ready  = (state == S_IDLE) || (state == S_ACCUM);
  assign w_ready   = (state == S_IDLE);
  assign out_valid = (state == S_OUTPUT);
  assign busy      = (state != S_IDLE);
  assign out_data  = out_q;
  assign err_last  = err_q;

  assign in_fire = in_valid && in_ready;
  assign w_fire  = w_valid && w_ready;
  assign start   = in_fire && (state == S_IDLE);
  assign at_last = (tap == LAST_TAP);

  // Tap 0 is multiplied in the same cycle the mode is latched, so it must see
  // the live configuration; later taps use the latched copy.
  assign mode_signed = (state == S_IDLE) ? cfg_signed : signed_q;

  function automatic logic [PROD_W-1:0] mul(input logic [DATA_WIDTH-1:0] a,
                                            input logic [DATA_WIDTH-1:0] b,
                                            input logic                  sgn);
    logic [PROD_W-1:0] ps;
    logic [PROD_W-1:0] pu;
    ps = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) *
         $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
    pu = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    return sgn ? ps : pu;
  endfunction

  function automatic logic [ACC_WIDTH-1:0] extend(input logic [PROD_W-1:0] p,
                                                  input logic              sgn);
    return sgn ? ACC_WIDTH'($signed(p)) : ACC_WIDTH'(p);
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (in_fire) state_next = at_last ? S_DRAIN : S_ACCUM;
      S_ACCUM:  if (in_fire && at_last) state_next = S_DRAIN;
      // Wait until the last product has left stage 1 and been accumulated.
      S_DRAIN:  if (!s1_valid) state_next = S_OUTPUT;
      S_OUTPUT: if (out_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- control regs
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap      <= '0;
      signed_q <= 1'b0;
      relu_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (in_fire) tap <= at_last ? '0 : tap + 1'b1;
      if (start) begin
        signed_q <= cfg_signed;
        relu_q   <= cfg_relu;
      end
      // Length is set by the counter alone; a misplaced in_last only flags.
      err_q <= in_fire && (in_last != at_last);
    end
  end

  // -------------------------------------------------------- weight bank
  // NOTE: the bank is storage, not state; it has no reset so weights survive
  // a mid-patch abort and it can map onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (w_fire && (32'(w_ch) < NUM_CH) && (32'(w_idx) < TAPS))
      wbank[w_ch][w_idx] <= w_data;
  end

  // NOTE: every always_comb output gets a value on every path to avoid latches.
  always_comb begin
    prod_next = '0;
    for (int c = 0; c < NUM_CH; c++)
      prod_next[c] = mul(wbank[c][tap], in_data, mode_signed);
  end

  // ------------------------------------------------- MAC pipeline stages
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
    end else begin
      s1_valid <= in_fire;
      if (in_fire) s1_prod <= prod_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (start) begin
      acc <= '0;
    end else if (s1_valid) begin
      for (int c = 0; c < NUM_CH; c++)
        acc[c] <= acc[c] + extend(s1_prod[c], signed_q);
    end
  end

  // -------------------------------------------------- output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else if ((state == S_DRAIN) && !s1_valid) begin
      for (int c = 0; c < NUM_CH; c++)
        out_q[c] <= (signed_q && relu_q && acc[c][ACC_WIDTH-1]) ? '0 : acc[c];
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed self-checking bench for conv_mac_engine with hand-computed results.
module tb_conv_mac_engine;

  localparam int DW   = 8;
  localparam int NC   = 4;
  localparam int TAPS = 9;
  localparam int AW   = 20;
  localparam int OW   = NC * AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_signed, cfg_relu;
  logic          w_valid, w_ready;
  logic [1:0]    w_ch;
  logic [3:0]    w_idx;
  logic [DW-1:0] w_data;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [OW-1:0] out_data;
  logic          err_last, busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] pix [TAPS];

  always #5 clk = ~clk;

  conv_mac_engine #(.DATA_WIDTH(DW), .FILTER_SIZE(3), .NUM_CH(NC)) dut (
    .clk(clk), .rst(rst), .cfg_signed(cfg_signed), .cfg_relu(cfg_relu),
    .w_valid(w_valid), .w_ready(w_ready), .w_ch(w_ch), .w_idx(w_idx),
    .w_data(w_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err_last(err_last),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [OW-1:0] got,
                       input logic [OW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] pack4(input logic [AW-1:0] c0, input logic [AW-1:0] c1,
                                          input logic [AW-1:0] c2, input logic [AW-1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic wr(input int ch, input int idx, input logic [DW-1:0] val);
    w_valid = 1'b1;
    w_ch    = 2'(ch);
    w_idx   = 4'(idx);
    w_data  = val;
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic load_all(input logic [DW-1:0] val);
    for (int c = 0; c < NC; c++)
      for (int t = 0; t < TAPS; t++) wr(c, t, val);
  endtask

  task automatic load_basic();
    for (int t = 0; t < TAPS; t++) begin
      wr(0, t, 8'd1);
      wr(1, t, 8'd2);
      wr(2, t, 8'd0);
      wr(3, t, 8'(t + 1));
    end
  endtask

  task automatic set_pix_ramp();
    for (int t = 0; t < TAPS; t++) pix[t] = 8'(t + 1);
  endtask

  task automatic set_pix_const(input logic [DW-1:0] v);
    for (int t = 0; t < TAPS; t++) pix[t] = v;
  endtask

  // Streams pix[] with in_last on last_at; stops before tap stop_at; at tap
  // wr_at also attempts a write of wr_val to ch0/tap0.
  task automatic feed(input int last_at, input int stop_at, input int wr_at,
                      input logic [DW-1:0] wr_val);
    for (int i = 0; i < TAPS; i++) begin
      if (i == stop_at) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      in_valid = 1'b1;
      in_data  = pix[i];
      in_last  = (i == last_at);
      check($sformatf("in_ready_t%0d", i), in_ready, 1'b1);
      if (i == wr_at) begin
        w_valid = 1'b1;
        w_ch    = 2'd0;
        w_idx   = 4'd0;
        w_data  = wr_val;
        check($sformatf("w_ready_t%0d", i), w_ready, i == 0);
      end
      @(posedge clk); #1;
      w_valid = 1'b0;
      check($sformatf("err_last_t%0d", i), err_last, (i == last_at) != (i == TAPS - 1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called 1 time unit after the last-tap edge; latency is fixed at 2 edges.
  task automatic collect(input string tag, input int hold, input logic [OW-1:0] exp);
    check({tag, "_lat0_valid"}, out_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
    @(posedge clk); #1;
    check({tag, "_lat1_valid"}, out_valid, 1'b0);
    check({tag, "_drain_in_ready"}, in_ready, 1'b0);
    @(posedge clk); #1;
    check({tag, "_lat2_valid"}, out_valid, 1'b1);
    for (int c = 0; c < NC; c++)
      check($sformatf("%s_ch%0d", tag, c), out_data[c*AW +: AW], exp[c*AW +: AW]);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check($sformatf("%s_hold%0d_data", tag, h), out_data, exp);
      check($sformatf("%s_hold%0d_valid", tag, h), out_valid, 1'b1);
      check($sformatf("%s_hold%0d_in_ready", tag, h), in_ready, 1'b0);
      check($sformatf("%s_hold%0d_w_ready", tag, h), w_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, out_valid, 1'b0);
    check({tag, "_post_busy"}, busy, 1'b0);
    check({tag, "_post_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    cfg_signed = 1'b0; cfg_relu = 1'b0;
    w_valid = 1'b0; w_ch = '0; w_idx = '0; w_data = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_err_last", err_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_w_ready", w_ready, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Unsigned basic patch with 5 cycles of backpressure.
    load_basic();
    set_pix_ramp();
    feed(8, -1, -1, 8'd0);
    collect("basic", 5, pack4(20'd45, 20'd90, 20'd0, 20'd285));

    // Signed, ch0 = -1 everywhere, pixels all 2.
    for (int t = 0; t < TAPS; t++) wr(0, t, 8'hFF);
    set_pix_const(8'd2);
    cfg_signed = 1'b1; cfg_relu = 1'b0;
    feed(8, -1, -1, 8'd0);
    collect("sgn", 0, pack4(20'hFFFEE, 20'd36, 20'd0, 20'd90));
    cfg_relu = 1'b1;
    feed(8, -1, -1, 8'd0);
    collect("relu", 0, pack4(20'd0, 20'd36, 20'd0, 20'd90));
    cfg_signed = 1'b0;
    feed(8, -1, -1, 8'd0);
    collect("uns_relu", 0, pack4(20'd4590, 20'd36, 20'd0, 20'd90));
    cfg_relu = 1'b0;

    // Extremes.
    load_all(8'hFF);
    set_pix_const(8'hFF);
    feed(8, -1, -1, 8'd0);
    collect("max_u", 0, pack4(20'd585225, 20'd585225, 20'd585225, 20'd585225));
    load_all(8'h80);
    set_pix_const(8'h80);
    cfg_signed = 1'b1;
    feed(8, -1, -1, 8'd0);
    collect("min_s", 0, pack4(20'd147456, 20'd147456, 20'd147456, 20'd147456));
    cfg_signed = 1'b0;

    // Early in_last (tap 4, none on tap 8) and a write attempt mid-patch.
    load_basic();
    set_pix_ramp();
    feed(4, -1, 3, 8'd100);
    collect("early_last", 0, pack4(20'd45, 20'd90, 20'd0, 20'd285));

    // Write accepted alongside the first pixel: old weight used this patch.
    feed(8, -1, 0, 8'd10);
    collect("cowrite_old", 0, pack4(20'd45, 20'd90, 20'd0, 20'd285));
    feed(8, -1, -1, 8'd0);
    collect("cowrite_new", 0, pack4(20'd54, 20'd90, 20'd0, 20'd285));

    // Reset after tap 5 aborts the patch; weights are retained.
    feed(8, 6, -1, 8'd0);
    rst = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    feed(8, -1, -1, 8'd0);
    collect("after_rst", 0, pack4(20'd54, 20'd90, 20'd0, 20'd285));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
